// File: rtl/pinwheel_ram_pkg.sv
// Shared types, the word-address width and the byte-merge helper for pinwheel_ram_ctrl.
// The RMW states exist only when PINWHEEL_RAM_CTRL_RMW_EN is defined.
package pinwheel_ram_pkg;

  localparam int WORD_ADDR_W = 10;

`ifdef PINWHEEL_RAM_CTRL_RMW_EN
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    RMW_WR,
    RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;
`endif

  // A set mask bit selects the byte from new_word; a clear bit keeps old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pinwheel_ram_ctrl.sv
// Single-outstanding request controller in front of a 1-cycle registered-read RAM.
// Define PINWHEEL_RAM_CTRL_RMW_EN to enable read-modify-write for partial byte masks.
module pinwheel_ram_ctrl
  import pinwheel_ram_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [WORD_ADDR_W-1:0] ram_raddr,
  input  logic [31:0]            ram_rdata,
  output logic [WORD_ADDR_W-1:0] ram_waddr,
  output logic [31:0]            ram_wdata,
  output logic                   ram_wren
);

  state_t                 state_reg, state_next;
  logic [WORD_ADDR_W-1:0] addr_reg;
  logic [31:0]            rsp_data_reg, rsp_data_next;
  logic                   rsp_err_reg, rsp_err_next;
  logic [WORD_ADDR_W-1:0] req_word;
  logic                   accept;
  logic                   wren_raw;
  logic                   unused_addr_bits;

`ifdef PINWHEEL_RAM_CTRL_RMW_EN
  logic [31:0] wdata_reg;
  logic [3:0]  mask_reg;
  logic [31:0] merge_reg, merge_next;
`endif

  // Byte-offset bits never reach the RAM; addresses wrap naturally at 1024 words.
  assign req_word         = req_addr[WORD_ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[1:0];
  assign accept           = req_valid && (state_reg == IDLE);

  always_comb begin
    state_next    = state_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
    merge_next    = merge_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (!req_write) begin
            state_next = RD_WAIT;
          end else if (req_mask == 4'hF || req_mask == 4'h0) begin
            state_next    = RESP;
            rsp_data_next = 32'd0;
            rsp_err_next  = 1'b0;
          end else begin
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
            state_next    = RMW_WAIT;
`else
            state_next    = RESP;
            rsp_data_next = 32'd0;
            rsp_err_next  = 1'b1;
`endif
          end
        end
      end
      RD_WAIT: begin
        state_next    = RESP;
        rsp_data_next = ram_rdata;
        rsp_err_next  = 1'b0;
      end
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
      RMW_WAIT: begin
        merge_next = merge_bytes(ram_rdata, wdata_reg, mask_reg);
        state_next = RMW_WR;
      end
      RMW_WR: begin
        state_next    = RESP;
        rsp_data_next = 32'd0;
        rsp_err_next  = 1'b0;
      end
`endif
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      rsp_data_reg <= 32'd0;
      rsp_err_reg  <= 1'b0;
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
      wdata_reg    <= 32'd0;
      mask_reg     <= 4'd0;
      merge_reg    <= 32'd0;
`endif
    end else begin
      state_reg    <= state_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
      merge_reg    <= merge_next;
`endif
      if (accept) begin
        addr_reg  <= req_word;
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
        wdata_reg <= req_wdata;
        mask_reg  <= req_mask;
`endif
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign ram_raddr = (state_reg == IDLE) ? req_word : addr_reg;

`ifdef PINWHEEL_RAM_CTRL_RMW_EN
  assign wren_raw  = (accept && req_write && req_mask == 4'hF) || (state_reg == RMW_WR);
  assign ram_waddr = (state_reg == RMW_WR) ? addr_reg : req_word;
  assign ram_wdata = (state_reg == RMW_WR) ? merge_reg : req_wdata;
`else
  assign wren_raw  = accept && req_write && req_mask == 4'hF;
  assign ram_waddr = req_word;
  assign ram_wdata = req_wdata;
`endif

  // Gating with rst_n kills an in-flight write the instant reset asserts.
  assign ram_wren = rst_n && wren_raw;

endmodule

// File: tb/tb_pinwheel_ram_ctrl.sv
// Randomized self-checking bench for pinwheel_ram_ctrl with a behavioural RAM and memory model.
// Works with and without PINWHEEL_RAM_CTRL_RMW_EN defined.
module tb_pinwheel_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  ram_raddr;
  logic [31:0] ram_rdata;
  logic [9:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic        ram_wren;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  int          wren_cnt;
  int          n_checks;
  int          n_fail;
  int          n_txn;

  pinwheel_ram_ctrl #(.ADDR_BITS(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle registered read plus a backdoor port for preloading.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    ram_rdata <= mem[ram_raddr];
  end

  always @(posedge clk) begin
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] word, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = word;
    bd_data = data;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    ref_mem[word] = data;
  endtask

  task automatic scramble_inputs();
    req_write = 1'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_mask  = 4'($urandom);
  endtask

  task automatic do_req(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] m, input int bp, output logic [31:0] data_out);
    logic [9:0]  word;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        seen;
    int          exp_lat, exp_wr, edges, w0;
    word     = addr[11:2];
    exp_data = 32'd0;
    exp_err  = 1'b0;
    exp_lat  = 1;
    exp_wr   = 0;
    if (!wr) begin
      exp_data = ref_mem[word];
      exp_lat  = 2;
    end else if (m == 4'hF) begin
      ref_mem[word] = wd;
      exp_wr = 1;
    end else if (m != 4'h0) begin
`ifdef PINWHEEL_RAM_CTRL_RMW_EN
      for (int b = 0; b < 4; b++) begin
        if (m[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
      end
      exp_lat = 3;
      exp_wr  = 1;
`else
      exp_err = 1'b1;
`endif
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = m;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    w0 = wren_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();

    edges = 1;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(edges), 32'(exp_lat));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    data_out = rsp_data;

    for (int c = 0; c < bp; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("wren_count", 32'(wren_cnt - w0), 32'(exp_wr));
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    n_txn++;
    $display("txn %0d wr=%0d addr=%h wdata=%h mask=%h bp=%0d -> data=%h err=%0d lat=%0d",
             n_txn, wr, addr, wd, m, bp, data_out, rsp_err, edges);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  word;
    int          sel, mism;
    n_checks  = 0;
    n_fail    = 0;
    n_txn     = 0;
    wren_cnt  = 0;
    bd_we     = 1'b0;
    bd_addr   = '0;
    bd_data   = '0;
    rsp_ready = 1'b0;
    // Drive a full-write request during reset: the write enable must stay low.
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h004;
    req_wdata = 32'h12345678;
    req_mask  = 4'hF;
    #3;
    chk("reset_wren", 32'(ram_wren), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;

    for (int w = 0; w < 16; w++) poke(10'(w), $urandom);
    for (int w = 1020; w < 1024; w++) poke(10'(w), $urandom);

    // Full write then read back.
    do_req(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, d);
    do_req(1'b0, 12'h004, 32'h0, 4'h0, 0, d);
    chk("wr_rd_deadbeef", d, 32'hDEADBEEF);

`ifdef PINWHEEL_RAM_CTRL_RMW_EN
    poke(10'd4, 32'h11223344);
    do_req(1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, 0, d);
    do_req(1'b0, 12'h010, 32'h0, 4'h0, 0, d);
    chk("rmw_merge", d, 32'h11BB33DD);

    // Reset while the merged word is being written: RAM must stay untouched.
    poke(10'd5, 32'hA5A5_5A5A);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h014;
    req_wdata = 32'hFFFF_FFFF;
    req_mask  = 4'b0110;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_wr_wren", 32'(ram_wren), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_wren", 32'(ram_wren), 32'd0);
    chk("rmw_rst_valid", 32'(rsp_valid), 32'd0);
    chk("rmw_rst_data", rsp_data, 32'd0);
    chk("rmw_rst_err", 32'(rsp_err), 32'd0);
    chk("rmw_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 12'h014, 32'h0, 4'h0, 0, d);
    chk("rmw_rst_word", d, 32'hA5A5_5A5A);
`else
    poke(10'd6, 32'h55667788);
    do_req(1'b1, 12'h018, 32'hFFFF_FFFF, 4'b0011, 0, d);
    do_req(1'b1, 12'h018, 32'hFFFF_FFFF, 4'b0000, 0, d);
    do_req(1'b0, 12'h018, 32'h0, 4'h0, 0, d);
    chk("norm_word_kept", d, 32'h55667788);
`endif

    // Backpressure on a read response.
    do_req(1'b0, 12'h008, 32'h0, 4'h0, 5, d);

    // Wrap and misaligned byte offsets.
    poke(10'd1023, 32'hCAFE0123);
    poke(10'd0, 32'h0BADF00D);
    do_req(1'b0, 12'hFFF, 32'h0, 4'h0, 0, d);
    chk("wrap_top", d, 32'hCAFE0123);
    do_req(1'b0, 12'h003, 32'h0, 4'h0, 0, d);
    chk("wrap_zero", d, 32'h0BADF00D);

    // Reset while a response is pending drops it without a handshake.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h020;
    req_wdata = 32'h600D_CAFE;
    req_mask  = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ref_mem[8] = 32'h600D_CAFE;
    @(negedge clk);
    chk("resp_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
    chk("resp_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 150; t++) begin
      logic [3:0] m;
      sel  = int'($urandom_range(0, 19));
      word = (sel < 16) ? 10'(sel) : 10'(1004 + sel);
      case ($urandom_range(0, 3))
        0:       m = 4'hF;
        1:       m = 4'h0;
        default: m = 4'($urandom);
      endcase
      do_req(1'($urandom), {word, 2'($urandom)}, $urandom, m,
             int'($urandom_range(0, 3)), d);
    end

    mism = 0;
    for (int w = 0; w < 16; w++) if (mem[w] !== ref_mem[w]) mism++;
    for (int w = 1020; w < 1024; w++) if (mem[w] !== ref_mem[w]) mism++;
    chk("mem_scan", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pinwheel_ram_ctrl.md
PINWHEEL_RAM_CTRL -- requirements
Module: pinwheel_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, byte-address width; word address = ADDR_BITS-2 = 10 bits.
REQ-002 SHALL have ports, in order:
- clk in 1: single clock.
- rst_n in 1: reset, asynchronous, active-low.
- req_valid in 1: request valid.
- req_ready out 1: request ready.
- req_write in 1: 1 = write, 0 = read.
- req_addr in ADDR_BITS: byte address; [1:0] ignored.
- req_wdata in 32: write data.
- req_mask in 4: byte enables.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response ready.
- rsp_data out 32: read data; 0 for writes.
- rsp_err out 1: request rejected.
- ram_raddr out 10, ram_rdata in 32, ram_waddr out 10, ram_wdata out 32, ram_wren out 1: RAM port; 1-cycle registered read.
REQ-003 SHALL define a request as accepted at a rising edge where req_valid and req_ready are both 1.

Function
REQ-004 SHALL implement the FSM states IDLE, RD_WAIT, RMW_WAIT, RMW_WR and RESP.
REQ-005 SHALL drive req_ready = (state == IDLE); exactly one request outstanding.
REQ-006 SHALL, in IDLE, drive ram_raddr = req_addr[11:2] combinationally.
REQ-007 SHALL handle a read as follows: on accept, IDLE -> RD_WAIT; at the next edge latch ram_rdata into rsp_data and go to RESP; rsp_valid is 1 after the second edge following accept.
REQ-008 SHALL handle a full write (mask 4'hF) as follows: ram_wren, ram_waddr and ram_wdata are driven combinationally from the request in the accept cycle; the RAM is written at the accept edge; then IDLE -> RESP with rsp_data 0.
REQ-009 SHALL handle a partial write (mask not 0 and not F) as follows:
- IDLE -> RMW_WAIT.
- Next edge: merge old word and req_wdata per byte (mask bit 1 takes the new byte) into a register; -> RMW_WR.
- In RMW_WR: ram_wren=1 with the merged word; the write occurs at the RMW_WR exit edge; -> RESP.
REQ-010 SHALL, for a mask=0 write, perform no RAM write and go IDLE -> RESP with rsp_data 0 and rsp_err 0.
REQ-011 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready=1, then go to IDLE; with rsp_ready held at 1, the next request is accepted one cycle after the response handshake.
REQ-012 SHALL latch the address, data and mask at accept, so that request inputs are don't-care after accept.
REQ-013 SHALL keep ram_wren=0 in every state and cycle not named in REQ-008 and REQ-009.
REQ-014 SHALL wrap addresses modulo 1024 words with no range error.

Reset
REQ-015 SHALL, on rst_n low, asynchronously set state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0 and the merge register=0.
REQ-016 SHALL force ram_wren=0 combinationally while rst_n=0.
REQ-017 SHALL, on reset in RMW_WAIT or RMW_WR, abort the pending write so that the RAM is not modified.
REQ-018 SHALL, on reset in RESP, drop the pending response without a handshake.

Configuration
REQ-019 SHALL, with PINWHEEL_RAM_CTRL_RMW_EN defined, handle partial writes per REQ-009.
REQ-020 SHALL, without PINWHEEL_RAM_CTRL_RMW_EN, handle a partial write as IDLE -> RESP with rsp_err=1 and no RAM access; the RMW_WAIT and RMW_WR states and the merge register are omitted; all other behaviour is identical.

Structure
REQ-021 SHALL place the state enum, the WORD_ADDR_W=10 constant and the byte-merge function in package pinwheel_ram_pkg.
REQ-022 SHALL use no sub-module; the RAM is instantiated by the parent alongside this block.

Verification
REQ-023 SHALL cover a full write then a read: write 0x004 data 0xDEADBEEF mask F, then read 0x004 -> rsp_data 0xDEADBEEF, rsp_valid 2 edges after read accept.
REQ-024 SHALL cover a partial write (RMW_EN): word 0x010 = 0x11223344, write 0xAABBCCDD mask 4'b0101 -> read back 0x11BB33DD; ram_wren high exactly one cycle.
REQ-025 SHALL cover backpressure: rsp_ready=0 for 5 cycles after a read -> rsp_valid/rsp_data stable, req_ready=0 throughout, no RAM write.
REQ-026 SHALL cover a reset mid-RMW: assert rst_n=0 in RMW_WR -> ram_wren=0 immediately, word unchanged, all outputs at reset values.
REQ-027 SHALL cover the macro off: write mask 4'b0011 -> rsp_err=1, word unchanged; mask 0 write -> rsp_err=0, no write.
REQ-028 SHALL cover wrap: a read at byte address 0xFFC returns word 1023 and a read at 0x000 returns word 0, with misaligned bits [1:0]=3 ignored.
